bin2bcd_disp: RTL and testbench
===============================

// Module: bin2bcd_disp
// PURPOSE
//  Sequential binary-to-BCD converter (shift-add-3 / double dabble) feeding the
//  6-digit seven-segment driver. Accepts an unsigned binary value on a start
//  pulse and produces packed BCD digits plus a display-enable flag. The outputs
//  connect directly to the driver's data and en inputs.
// PARAMETERS
//  BIN_W   20  width of the binary input; one shift cycle per bit
//  DIGITS  6   BCD digits output; data width = 4*DIGITS
// PORTS
//  clk     in   1         system clock (50 MHz); sole clock domain
//  rst_n   in   1         synchronous, active-low reset, sampled on posedge clk
//  start   in   1         conversion request; sampled only in IDLE
//  bin_in  in   BIN_W     unsigned value, latched on the accepted start
//  busy    out  1         high while a conversion is in progress
//  done    out  1         one-cycle pulse when data is updated
//  ovf     out  1         last converted value > 10^DIGITS-1
//  data    out  4*DIGITS  packed BCD, data[3:0] = units (rightmost digit)
//  en      out  1         low until the first conversion completes, then high
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state=IDLE; busy=0, done=0, ovf=0,
//    data=0, en=0. The work registers are cleared.
//  - States:
//    - IDLE: start=1 -> latch bin_in into the shift register, clear the BCD
//      accumulator (4*DIGITS+4 bits, one guard digit), set bit counter=0,
//      set busy=1, go to SHIFT.
//    - SHIFT: on each clock, every accumulator digit >=5 gets +3. Then
//      {acc,bin} shifts left by 1. The counter increments.
//      After shift number BIN_W, at that same edge:
//      - register the result into data and ovf
//      - set done=1, busy=0, en=1
//      - go to IDLE.
//  - Latency: start sampled at edge k -> data, done, and ovf update at edge
//    k+BIN_W (20 clocks by default). done is high for exactly 1 cycle.
//  - start while busy=1: ignored; bin_in is not re-latched.
//  - A start during the cycle done=1 is accepted, so back-to-back conversions
//    occur every BIN_W+1 clocks.
//  - data, ovf, and en hold their values between conversions.
//    en never falls except on reset.
//  - ovf=1 when the guard digit or any input bit weight is beyond range, i.e.
//    bin_in > 10^DIGITS-1 (BIN_W=20: values 1000000..1048575).
//  - Reset mid-SHIFT: the conversion is aborted and the block returns to its
//    reset values on the next edge; no done pulse.
//  - Adds are per-digit 4-bit with no carry between digits; the guard digit
//    is never output.
// CONFIGURATION
//  BIN2BCD_SAT_EN defined:
//    - on ovf, data = all digits 4'h9 (24'h999999).
//  BIN2BCD_SAT_EN undefined:
//    - on ovf, data = the low DIGITS BCD digits (modulo 10^DIGITS).
//    - Example: 1048575 -> 24'h048575.
//  ovf is reported identically in both builds.
// TESTING
//  1. Reset released, no start -> busy=0, done=0, data=0, en=0 for 100 cycles.
//  2. bin_in=0, start pulse -> done exactly 20 clocks later;
//     data=24'h000000, ovf=0, en=1.
//  3. bin_in=123456 then bin_in=999999 -> data=24'h123456, then
//     data=24'h999999, ovf=0.
//     Drive the second start in the cycle the first done is high.
//  4. bin_in=1048575 -> ovf=1; data=24'h999999 with BIN2BCD_SAT_EN,
//     24'h048575 without.
//  5. start at cycle 0 (bin_in=42), then start with bin_in=7 at cycle 5
//     -> the second start is ignored; a single done with data=24'h000042.
//  6. rst_n=0 at cycle 10 of a conversion -> no done; all outputs 0 next edge;
//     en=0. A fresh start after release converts correctly.

Source files
------------

// File: rtl/bin2bcd_disp.sv
// Sequential binary-to-BCD converter (shift-add-3) feeding a 7-segment driver.
// Ports: clk, rst_n (sync, active-low), start, bin_in -> busy, done, ovf,
// data (packed BCD, units in data[3:0]), en (high after first conversion).
// Optional build macro: BIN2BCD_SAT_EN saturates data to all nines on ovf.
module bin2bcd_disp #(
  parameter int BIN_W  = 20,
  parameter int DIGITS = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [4*DIGITS-1:0]   data,
  output logic                  en
);

  localparam int ACC_W = 4*DIGITS + 4;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [BIN_W-1:0]    r_bin;
  logic [ACC_W-1:0]    r_acc;
  logic [CNT_W-1:0]    r_cnt;
  logic [4*DIGITS-1:0] r_data;
  logic                r_ovf;
  logic                r_done;
  logic                r_en;

  logic                w_busy;
  logic                w_load;
  logic                w_last;
  logic [ACC_W-1:0]    w_adj;
  logic [ACC_W-1:0]    w_acc_sh;
  logic [BIN_W-1:0]    w_bin_sh;
  logic                w_ovf;
  logic [4*DIGITS-1:0] w_data_nxt;

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (start)  w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // output / control decode
  always_comb begin
    w_busy = (r_state == S_SHIFT);
    w_load = (r_state == S_IDLE) && start;
    w_last = (r_state == S_SHIFT) &&
             (r_cnt == CNT_W'(BIN_W - 1));
  end

  // per-digit add-3, no carry between digits (guard digit included)
  always_comb begin
    w_adj = r_acc;
    for (int d = 0; d <= DIGITS; d++) begin
      if (r_acc[4*d +: 4] >= 4'd5)
        w_adj[4*d +: 4] = r_acc[4*d +: 4] + 4'd3;
    end
  end

  // shift {acc,bin} left by one; the top accumulator bit falls off
  assign w_acc_sh = ACC_W'({w_adj, r_bin[BIN_W-1]});
  assign w_bin_sh = {r_bin[BIN_W-2:0], 1'b0};
  assign w_ovf    = |w_acc_sh[ACC_W-1 -: 4];

`ifdef BIN2BCD_SAT_EN
  assign w_data_nxt = w_ovf ? {DIGITS{4'h9}}
                            : w_acc_sh[4*DIGITS-1:0];
`else
  assign w_data_nxt = w_acc_sh[4*DIGITS-1:0];
`endif

  // datapath
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bin  <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_data <= '0;
      r_ovf  <= 1'b0;
      r_done <= 1'b0;
      r_en   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_load) begin
        r_bin <= bin_in;
        r_acc <= '0;
        r_cnt <= '0;
      end else if (w_busy) begin
        r_bin <= w_bin_sh;
        r_acc <= w_acc_sh;
        r_cnt <= r_cnt + CNT_W'(1);
        if (w_last) begin
          r_data <= w_data_nxt;
          r_ovf  <= w_ovf;
          r_done <= 1'b1;
          r_en   <= 1'b1;
        end
      end
    end
  end

  assign busy = w_busy;
  assign done = r_done;
  assign ovf  = r_ovf;
  assign data = r_data;
  assign en   = r_en;

endmodule

// File: tb/tb_bin2bcd_disp.sv
// Self-checking bench for bin2bcd_disp.
// Scoreboard of {ovf,data} pushed at start, popped at done.
module tb_bin2bcd_disp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [19:0] bin_in = '0;
  logic        busy, done, ovf, en;
  logic [23:0] data;

  int checks = 0;
  int failures = 0;
  logic [24:0] sb[$];

`ifdef BIN2BCD_SAT_EN
  localparam logic SAT = 1'b1;
`else
  localparam logic SAT = 1'b0;
`endif

  bin2bcd_disp #(.BIN_W(20), .DIGITS(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .bin_in(bin_in), .busy(busy), .done(done),
    .ovf(ovf), .data(data), .en(en)
  );

  always #10 clk = ~clk;

  function automatic logic [24:0] model(input int unsigned v);
    logic [23:0] d;
    int unsigned t;
    logic o;
    t = v;
    d = '0;
    for (int i = 0; i < 6; i++) begin
      d[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    o = (v > 999999);
    if (o && SAT) d = 24'h999999;
    return {o, d};
  endfunction

  task automatic kick(input int unsigned v);
    bin_in = 20'(v);
    start = 1'b1;
    sb.push_back(model(v));
  endtask

  task automatic wait_done(output int n);
    n = -1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      checks++;
      if ({busy, done, ovf, en, data} !== 28'h0) begin
        failures++;
        $display("FAIL reset_idle cyc=%0d got b=%b d=%b o=%b en=%b data=%h want all 0",
                 i, busy, done, ovf, en, data);
      end
    end
  endtask

  task automatic test_zero;
    int n;
    logic [24:0] e;
    @(negedge clk);
    kick(0);
    wait_done(n);
    checks++;
    if (n !== 21) begin
      failures++;
      $display("FAIL zero_latency got %0d want 21", n);
    end
    e = sb.size() > 0 ? sb.pop_front() : 25'h1ffffff;
    checks++;
    if ({ovf, data} !== e || en !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL zero_result got o=%b data=%h en=%b busy=%b want o=%b data=%h en=1 busy=0",
               ovf, data, en, busy, e[24], e[23:0]);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || en !== 1'b1) begin
      failures++;
      $display("FAIL done_pulse got done=%b en=%b want done=0 en=1", done, en);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    logic [24:0] e;
    @(negedge clk);
    kick(123456);
    wait_done(n);
    if (n > 0) kick(999999);
    e = sb.size() > 0 ? sb.pop_front() : 25'h1ffffff;
    checks++;
    if (n !== 21 || {ovf, data} !== e) begin
      failures++;
      $display("FAIL b2b_first got n=%0d o=%b data=%h want n=21 o=%b data=%h",
               n, ovf, data, e[24], e[23:0]);
    end
    wait_done(n);
    e = sb.size() > 0 ? sb.pop_front() : 25'h1ffffff;
    checks++;
    if (n !== 21 || {ovf, data} !== e) begin
      failures++;
      $display("FAIL b2b_second got n=%0d o=%b data=%h want n=21 o=%b data=%h",
               n, ovf, data, e[24], e[23:0]);
    end
  endtask

  task automatic test_ovf;
    int n;
    logic [24:0] e;
    int unsigned vals[3] = '{1048575, 1000000, 654321};
    foreach (vals[k]) begin
      @(negedge clk);
      kick(vals[k]);
      wait_done(n);
      e = sb.size() > 0 ? sb.pop_front() : 25'h1ffffff;
      checks++;
      if (n !== 21 || {ovf, data} !== e) begin
        failures++;
        $display("FAIL ovf_%0d got n=%0d o=%b data=%h want n=21 o=%b data=%h",
                 vals[k], n, ovf, data, e[24], e[23:0]);
      end
    end
  endtask

  task automatic test_ignore;
    int nd;
    int at;
    logic [24:0] e;
    nd = 0;
    at = -1;
    e = '0;
    @(negedge clk);
    kick(42);
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (i == 5) begin
        bin_in = 20'd7;
        start = 1'b1;
      end
      if (i == 6) start = 1'b0;
      if (done === 1'b1) begin
        nd++;
        if (at < 0) begin
          at = i;
          e = sb.size() > 0 ? sb.pop_front() : 25'h1ffffff;
          checks++;
          if ({ovf, data} !== e) begin
            failures++;
            $display("FAIL ignore_data got o=%b data=%h want o=%b data=%h",
                     ovf, data, e[24], e[23:0]);
          end
        end
      end
    end
    checks++;
    if (nd !== 1 || at !== 21) begin
      failures++;
      $display("FAIL ignore_count got dones=%0d at=%0d want 1 at 21", nd, at);
    end
  endtask

  task automatic test_reset_abort;
    int n;
    int nd;
    logic [24:0] e;
    nd = 0;
    @(negedge clk);
    kick(111111);
    repeat (10) begin
      @(negedge clk);
      start = 1'b0;
    end
    checks++;
    if (busy !== 1'b1 || en !== 1'b1) begin
      failures++;
      $display("FAIL abort_pre got busy=%b en=%b want 1 1", busy, en);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, ovf, en, data} !== 28'h0) begin
      failures++;
      $display("FAIL abort_reset got b=%b d=%b o=%b en=%b data=%h want all 0",
               busy, done, ovf, en, data);
    end
    sb.delete();
    rst_n = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (done === 1'b1) nd++;
    end
    checks++;
    if (nd !== 0 || en !== 1'b0) begin
      failures++;
      $display("FAIL abort_nodone got dones=%0d en=%b want 0 0", nd, en);
    end
    kick(654321);
    wait_done(n);
    e = sb.size() > 0 ? sb.pop_front() : 25'h1ffffff;
    checks++;
    if (n !== 21 || {ovf, data} !== e || en !== 1'b1) begin
      failures++;
      $display("FAIL abort_fresh got n=%0d o=%b data=%h en=%b want n=21 o=%b data=%h en=1",
               n, ovf, data, en, e[24], e[23:0]);
    end
  endtask

  initial begin
    test_reset;
    test_zero;
    test_back_to_back;
    test_ovf;
    test_ignore;
    test_reset_abort;
    checks++;
    if (sb.size() !== 0) begin
      failures++;
      $display("FAIL sb_empty got %0d left want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
